// File: rtl/cia_serial_port_if.sv
// Register-bus view of the CIA serial data port: SDR write strobe, address,
// write data and the SDR readback value.
interface cia_serial_port_if;
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] sdr;

    modport master (output we, addr, data, input sdr);
    modport slave  (input we, addr, data, output sdr);
endinterface

// File: rtl/cia_serial_port.sv
// CIA serial data port: SDR register with an 8-bit shifter that either shifts
// in on external CNT rising edges or shifts out clocked by timer A underflows.
module cia_serial_port #(
    parameter int NBITS = 8
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              phi2_dn,
    cia_serial_port_if.slave  bus,
    input  logic              spmode,
    input  logic              ta_underflow,
    input  logic              cnt_in,
    input  logic              sp_in,
    output logic              cnt_out,
    output logic              sp_out,
    output logic              irq_sp
);

    localparam int CW = $clog2(NBITS) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state_q;
    logic [7:0]     sdr_q;
    logic [7:0]     shifter_q;
    logic [CW-1:0]  bitcnt_q;
    logic           cnt_prev_q;
    logic           cnt_out_q;
    logic           sp_out_q;
    logic           irq_q;
    logic           pending_q;
    logic           spmode_q;

    logic           sdr_wr;
    logic [7:0]     shift_in_d;

    assign sdr_wr     = bus.we && (bus.addr == 4'hC);
    assign shift_in_d = {shifter_q[6:0], sp_in};

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q    <= IDLE;
            sdr_q      <= 8'h00;
            shifter_q  <= 8'h00;
            bitcnt_q   <= '0;
            cnt_prev_q <= 1'b1;
            cnt_out_q  <= 1'b1;
            sp_out_q   <= 1'b1;
            irq_q      <= 1'b0;
            pending_q  <= 1'b0;
            spmode_q   <= spmode;
        end else if (phi2_dn) begin
            spmode_q   <= spmode;
            cnt_prev_q <= cnt_in;
            irq_q      <= 1'b0;
            if (sdr_wr) begin
                sdr_q <= bus.data;
            end

            if (spmode != spmode_q) begin
                // Mode switch aborts any transfer; shifter and SDR survive.
                state_q   <= IDLE;
                bitcnt_q  <= '0;
                pending_q <= 1'b0;
                cnt_out_q <= 1'b1;
                if (!spmode) begin
                    sp_out_q <= 1'b1;
                end
            end else if (!spmode) begin
                state_q   <= IDLE;
                cnt_out_q <= 1'b1;
                sp_out_q  <= 1'b1;
                if (!cnt_prev_q && cnt_in) begin
                    shifter_q <= shift_in_d;
                    if (bitcnt_q == LAST_BIT) begin
                        sdr_q    <= shift_in_d;
                        bitcnt_q <= '0;
                        irq_q    <= 1'b1;
                    end else begin
                        bitcnt_q <= bitcnt_q + 1'b1;
                    end
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt_out_q <= 1'b1;
                        if (ta_underflow && pending_q) begin
                            shifter_q <= sdr_q;
                            pending_q <= 1'b0;
                            sp_out_q  <= sdr_q[7];
                            bitcnt_q  <= '0;
                            state_q   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (ta_underflow) begin
                            if (cnt_out_q) begin
                                cnt_out_q <= 1'b0;
                            end else begin
                                cnt_out_q <= 1'b1;
                                if (bitcnt_q == LAST_BIT) begin
                                    irq_q    <= 1'b1;
                                    bitcnt_q <= '0;
                                    if (pending_q) begin
                                        shifter_q <= sdr_q;
                                        pending_q <= 1'b0;
                                        sp_out_q  <= sdr_q[7];
                                    end else begin
                                        // shifter[7] is the bit currently on SP.
                                        sp_out_q <= shifter_q[7];
                                        state_q  <= IDLE;
                                    end
                                end else begin
                                    shifter_q <= {shifter_q[6:0], 1'b0};
                                    bitcnt_q  <= bitcnt_q + 1'b1;
                                    sp_out_q  <= shifter_q[6];
                                end
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
                // A write coinciding with a reload queues the next byte.
                if (sdr_wr) begin
                    pending_q <= 1'b1;
                end
            end
        end
    end

    assign bus.sdr = sdr_q;
    assign cnt_out = cnt_out_q;
    assign sp_out  = sp_out_q;
    assign irq_sp  = irq_q;

endmodule

// File: tb/tb_cia_serial_port.sv
// Directed bench for cia_serial_port: input bytes, output bytes, back-to-back
// output, mode-switch abort and reset in the middle of an input byte.
module tb_cia_serial_port;

    logic clk = 1'b0;
    logic res_n = 1'b0;
    logic phi2_dn = 1'b0;
    logic spmode = 1'b0;
    logic ta_underflow = 1'b0;
    logic cnt_in = 1'b1;
    logic sp_in = 1'b1;
    logic cnt_out, sp_out, irq_sp;

    int tests = 0;
    int fails = 0;

    cia_serial_port_if bus ();

    cia_serial_port #(.NBITS(8)) dut (
        .clk          (clk),
        .res_n        (res_n),
        .phi2_dn      (phi2_dn),
        .bus          (bus.slave),
        .spmode       (spmode),
        .ta_underflow (ta_underflow),
        .cnt_in       (cnt_in),
        .sp_in        (sp_in),
        .cnt_out      (cnt_out),
        .sp_out       (sp_out),
        .irq_sp       (irq_sp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One phi2 period: a strobe clock followed by a quiet clock.
    task automatic tick();
        phi2_dn = 1'b1;
        @(posedge clk); #1;
        phi2_dn = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [7:0] d);
        bus.we = 1'b1; bus.addr = 4'hC; bus.data = d;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic ufl();
        ta_underflow = 1'b1;
        tick();
        ta_underflow = 1'b0;
    endtask

    task automatic in_bit(input logic b, input bit wr_77);
        cnt_in = 1'b0;
        tick();
        sp_in = b; cnt_in = 1'b1;
        if (wr_77) begin
            bus.we = 1'b1; bus.addr = 4'hC; bus.data = 8'h77;
        end
        tick();
        bus.we = 1'b0;
    endtask

    task automatic in_byte(input logic [7:0] v, input logic [7:0] prev, input bit wr_last);
        for (int i = 7; i >= 0; i--) begin
            in_bit(v[i], wr_last && (i == 0));
            if (i > 0) chk("in_irq_early", irq_sp, 1'b0);
            if (i == 1) chk("in_sdr_before", bus.sdr, prev);
            chk("in_cnt_out", cnt_out, 1'b1);
            chk("in_sp_out", sp_out, 1'b1);
        end
        chk("in_sdr", bus.sdr, v);
        chk("in_irq", irq_sp, 1'b1);
        tick();
        chk("in_irq_clear", irq_sp, 1'b0);
        $display("[TB] input byte %02h received, sdr=%02h", v, bus.sdr);
    endtask

    initial begin
        logic [7:0] pat;
        int k, idx, toggles;
        logic prev_cnt;

        bus.we = 1'b0; bus.addr = 4'h0; bus.data = 8'h00;

        // Reset with phi2_dn low
        @(posedge clk); #1;
        res_n = 1'b1;
        chk("rst_sdr", bus.sdr, 8'h00);
        chk("rst_cnt_out", cnt_out, 1'b1);
        chk("rst_sp_out", sp_out, 1'b1);
        chk("rst_irq", irq_sp, 1'b0);
        $display("[TB] reset done");

        // Input byte A5
        in_byte(8'hA5, 8'h00, 1'b0);

        // Output byte 3C
        spmode = 1'b1;
        tick();
        wr(8'h3C);
        chk("out_sdr", bus.sdr, 8'h3C);
        chk("out_idle_cnt", cnt_out, 1'b1);
        pat = 8'h3C; toggles = 0; prev_cnt = cnt_out;
        for (int u = 1; u <= 18; u++) begin
            ufl();
            k = (u - 1) / 2;
            idx = (k > 7) ? 0 : 7 - k;
            chk("out_sp", sp_out, pat[idx]);
            chk("out_cnt", cnt_out, (u >= 2 && u <= 17 && (u % 2 == 0)) ? 0 : 1);
            chk("out_irq", irq_sp, (u == 17));
            if (cnt_out !== prev_cnt) toggles++;
            prev_cnt = cnt_out;
        end
        chk("out_toggles", toggles, 16);
        $display("[TB] output byte 3C sent, %0d CNT toggles", toggles);

        // Back-to-back FF then 01
        wr(8'hFF);
        for (int u = 1; u <= 34; u++) begin
            ufl();
            if (u == 1) begin
                wr(8'h01);
                chk("b2b_sdr", bus.sdr, 8'h01);
            end
            chk("b2b_irq", irq_sp, (u == 17 || u == 33));
            if (u == 16) chk("b2b_sp_ff", sp_out, 1'b1);
            if (u == 17) chk("b2b_sp_reload", sp_out, 1'b0);
            if (u == 18) chk("b2b_no_gap", cnt_out, 1'b0);
            if (u == 29) chk("b2b_sp_bit1", sp_out, 1'b0);
            if (u == 31) chk("b2b_sp_bit0", sp_out, 1'b1);
            if (u == 34) chk("b2b_idle_cnt", cnt_out, 1'b1);
        end
        $display("[TB] back-to-back bytes FF,01 sent");

        // Abort after 5 output bits
        wr(8'h5A);
        for (int u = 1; u <= 12; u++) ufl();
        chk("abort_pre_cnt", cnt_out, 1'b0);
        spmode = 1'b0;
        tick();
        chk("abort_cnt", cnt_out, 1'b1);
        chk("abort_sp", sp_out, 1'b1);
        chk("abort_irq", irq_sp, 1'b0);
        chk("abort_sdr_kept", bus.sdr, 8'h5A);
        tick();
        chk("abort_irq2", irq_sp, 1'b0);
        $display("[TB] output aborted by mode change");
        in_byte(8'h81, 8'h5A, 1'b0);

        // Reset in the middle of an input byte; completing write loses
        for (int i = 0; i < 4; i++) in_bit(1'b1, 1'b0);
        res_n = 1'b0;
        @(posedge clk); #1;
        res_n = 1'b1;
        chk("midrst_sdr", bus.sdr, 8'h00);
        chk("midrst_irq", irq_sp, 1'b0);
        $display("[TB] reset mid-input");
        in_byte(8'hC3, 8'h00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cia_serial_port.md
Name: cia_serial_port

Overview:
- Serial data port of the CIA: SDR register (addr 'hC), 8-bit shifter, CNT/SP pin logic.
- Input mode: shifts in 8 bits clocked by external CNT rising edges.
- Output mode: shifts out 8 bits clocked by timer A underflows, generating CNT itself.
- Drives the SP interrupt source (sources[3]) of the downstream interrupt controller, one pulse per completed byte.

Parameters:
- NBITS, 8, bits per transfer; the bit counter is sized $clog2(NBITS)+1.

Ports:
- clk  in  1  system clock
- res_n  in  1  synchronous active-low reset
- phi2_dn  in  1  single-clk strobe, one per phi2 cycle; all state below updates only when high, except reset
- we  in  1  register write
- addr  in  4  register address
- data  in  8  write data
- spmode  in  1  CRA bit 6: 0 = input, 1 = output
- ta_underflow  in  1  timer A underflow, coincident with phi2_dn
- cnt_in  in  1  synchronized CNT pin level
- sp_in  in  1  synchronized SP pin level
- cnt_out  out  1  CNT pin drive, open-drain high = released
- sp_out  out  1  SP pin drive
- sdr  out  8  SDR readback value
- irq_sp  out  1  interrupt source to cia_interrupt sources[3]

Behaviour:
- Reset (res_n=0 at a clk edge): sdr=0, shifter=0, bitcnt=0, cnt_prev=1, cnt_out=1, sp_out=1, irq_sp=0, pending=0, state=IDLE.
- irq_sp timing:
  - Registered on the phi2_dn cycle in which a byte completes.
  - Held high until the next phi2_dn, then cleared. This guarantees the interrupt block samples it exactly once.
- SDR write (we && addr=='hC && phi2_dn): sdr<=data in either mode. In output mode, also pending<=1.
- Input mode (spmode=0):
  - cnt_out=1 and sp_out=1 at all times.
  - Each phi2_dn: cnt_prev<=cnt_in.
  - Rising edge (cnt_prev=0, cnt_in=1): shifter<={shifter[6:0],sp_in}, bitcnt<=bitcnt+1.
  - When bitcnt reaches 8 on that edge: sdr<={shifter[6:0],sp_in}, bitcnt<=0, irq_sp<=1.
  - A write to sdr on the completing cycle loses to the shift result.
- Output mode, states IDLE and SHIFT:
  - IDLE: cnt_out=1. On ta_underflow with pending=1: shifter<=sdr, pending<=0, sp_out<=sdr[7], bitcnt<=0, go to SHIFT. Underflows with pending=0 are ignored.
  - SHIFT, each ta_underflow: cnt_out<=~cnt_out.
  - SHIFT, low-to-high CNT transition: shifter<<=1, bitcnt+1, sp_out<=next MSB.
  - After the 8th rising CNT: irq_sp<=1 and cnt_out stays 1.
    - If pending=1: reload from sdr immediately (pending<=0) and stay in SHIFT. Back-to-back bytes need no idle cycle.
    - Else: go to IDLE, sp_out holds the last bit.
  - One byte costs 16 underflows.
  - A write landing on the same cycle as the reload sets pending for the following byte; the reload uses the old sdr value.
- Mode change (spmode toggles):
  - Any transfer in progress is aborted: state=IDLE, bitcnt=0, pending=0, cnt_out=1, no irq_sp.
  - shifter and sdr are retained.
- Reset mid-transfer: full reset values, no irq_sp.

Test Plan:
- Reset: res_n=0 one clk with phi2_dn=0 -> sdr=0, cnt_out=1, sp_out=1, irq_sp=0 on the next clk.
- Input byte: spmode=0, clock in 'hA5 MSB-first with 8 CNT rising edges -> sdr='hA5 and irq_sp=1 for exactly one phi2 period after the 8th edge; no irq after 7 edges.
- Output byte: spmode=1, write 'h3C, pulse ta_underflow 17 times -> first underflow loads, sp_out sequence 0,0,1,1,1,1,0,0, cnt_out toggles 16 times, one irq_sp pulse, state IDLE.
- Back-to-back output: write 'hFF, start, write 'h01 during the first byte -> second byte starts with no gap, two irq_sp pulses 16 underflows apart.
- Abort: spmode 1->0 after 5 output bits -> cnt_out=1 immediately, no irq_sp. A subsequent input byte 'h81 completes normally.
- Reset mid-input: 4 bits in, res_n=0 -> bitcnt=0. The next 8 CNT edges produce a clean byte.
